// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232 receive/transmit path: FSM encoding, parity modes and the
// baud divider calculation.
package rs232_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_ref_mhz,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(clk_ref_mhz) * 64'd1000000;
    den = 64'(baud_rate) * 64'(oversample);
    return 32'((num + den / 64'd2) / den);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable by a clear input so
// the tick phase can be aligned to an external event.
module rs232_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rs232_rx_core.sv
// Oversampling RS-232 receiver with majority-vote bit decisions, parity/framing checks and a
// break lockout that holds off new frames until the line has been seen high again.
module rs232_rx_core
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_REF    = 100,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_ref,
  input  logic                 rst_n,
  input  logic                 i_rx_pin,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_rx_busy,
  output logic                 o_rx_cfg_over
);

  localparam int unsigned DIV = calc_div(CLK_REF, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  // Input conditioning
  logic [1:0] sync_q;
  logic       edge_q;
  logic       rx_s;
  logic       fall;

  assign rx_s = sync_q[1];
  assign fall = edge_q & ~rx_s;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_rx_pin};
      edge_q <= rx_s;
    end
  end

  rx_state_e state_q, state_d;
  logic      tick;
  logic      tick_clr;

  // Held in clear while idle so the first tick lands DIV clocks after the start edge.
  assign tick_clr = (state_q == StIdle);

  rs232_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk_i (clk_ref),
    .rst_ni(rst_n),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Sampler
  logic [SW-1:0] smp_cnt_q, smp_cnt_d;
  logic [1:0]    smp_q, smp_d;
  logic          decide;
  logic          bit_val;

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    smp_d     = smp_q;
    if (state_q == StIdle) begin
      smp_cnt_d = '0;
    end else if (tick) begin
      smp_cnt_d = (smp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : smp_cnt_q + SW'(1);
      if (smp_cnt_q == SW'(MID - 1)) smp_d[0] = rx_s;
      if (smp_cnt_q == SW'(MID))     smp_d[1] = rx_s;
    end
  end

  assign decide  = tick && (smp_cnt_q == SW'(MID + 1));
  assign bit_val = maj3(smp_q[0], smp_q[1], rx_s);

  // Frame FSM
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    armed_d    = armed_q;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end
        if (fall && armed_q) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      StStart: begin
        if (decide) begin
          state_d = bit_val ? StIdle : StData;
        end
      end
      StData: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      StParity: begin
        if (decide) begin
          perr_acc_d = ((^shift_q) ^ bit_val) != (PARITY == PARITY_ODD);
          state_d    = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          if (!bit_val) begin
            ferr_acc_d = 1'b1;
          end
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            // Leave at the decision point so a back-to-back start edge is not missed.
            bit_cnt_d = '0;
            state_d   = StIdle;
            rx_data_d = shift_q;
            perr_d    = perr_acc_q;
            ferr_d    = ferr_acc_q | ~bit_val;
            valid_d   = 1'b1;
            if ((ferr_acc_q | ~bit_val) && !rx_s) begin
              armed_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      smp_cnt_q  <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      armed_q    <= 1'b1;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      armed_q    <= armed_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
    end
  end

  assign o_rx_data     = rx_data_q;
  assign o_parity_err  = perr_q;
  assign o_frame_err   = ferr_q;
  assign o_rx_valid    = valid_q;
  assign o_rx_cfg_over = valid_q;
  assign o_rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_rs232_rx_core.sv
// Bench for rs232_rx_core: three instances (8N1, 8E1, 8N2) exercised concurrently from a
// vector table plus hand-written sequences, results checked through per-instance scoreboards.
`timescale 1ns / 1ps
module tb_rs232_rx_core;

  localparam realtime BitNs = 8640.0;
  localparam int      BitCyc = 864;
  localparam int      NV = 6;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         par;
    int         nstop;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk_ref = 1'b0;
  logic       rst_n;
  logic       rst_x;
  logic       rx[3];
  logic [7:0] dout[3];
  logic       valid[3];
  logic       perr[3];
  logic       ferr[3];
  logic       busy[3];
  logic       cfg[3];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   vcnt[3];
  int   bcnt[3];
  logic pv[3];
  exp_t sbq[3][$];
  vec_t vecs[NV];

  always #5 clk_ref = ~clk_ref;

  rs232_rx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_n1 (
    .clk_ref      (clk_ref),
    .rst_n        (rst_n & rst_x),
    .i_rx_pin     (rx[0]),
    .o_rx_data    (dout[0]),
    .o_rx_valid   (valid[0]),
    .o_parity_err (perr[0]),
    .o_frame_err  (ferr[0]),
    .o_rx_busy    (busy[0]),
    .o_rx_cfg_over(cfg[0])
  );

  rs232_rx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_e1 (
    .clk_ref      (clk_ref),
    .rst_n        (rst_n),
    .i_rx_pin     (rx[1]),
    .o_rx_data    (dout[1]),
    .o_rx_valid   (valid[1]),
    .o_parity_err (perr[1]),
    .o_frame_err  (ferr[1]),
    .o_rx_busy    (busy[1]),
    .o_rx_cfg_over(cfg[1])
  );

  rs232_rx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_n2 (
    .clk_ref      (clk_ref),
    .rst_n        (rst_n),
    .i_rx_pin     (rx[2]),
    .o_rx_data    (dout[2]),
    .o_rx_valid   (valid[2]),
    .o_parity_err (perr[2]),
    .o_frame_err  (ferr[2]),
    .o_rx_busy    (busy[2]),
    .o_rx_cfg_over(cfg[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: compare every valid strobe against the oldest pending expectation.
  always @(negedge clk_ref) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) bcnt[k]++;
      if (pv[k]) check($sformatf("valid_one_cycle_dut%0d", k), 32'(valid[k]), 32'd0);
      if (valid[k]) begin
        vcnt[k]++;
        if (sbq[k].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid_dut%0d: got valid with data %h, want no valid", k,
                   dout[k]);
        end else begin
          e = sbq[k].pop_front();
          check($sformatf("data_dut%0d", k), 32'(dout[k]), 32'(e.data));
          check($sformatf("parity_err_dut%0d", k), 32'(perr[k]), 32'(e.perr));
          check($sformatf("frame_err_dut%0d", k), 32'(ferr[k]), 32'(e.ferr));
          check($sformatf("cfg_over_dut%0d", k), 32'(cfg[k]), 32'd1);
          check($sformatf("busy_low_at_valid_dut%0d", k), 32'(busy[k]), 32'd0);
        end
      end
      pv[k] = valid[k];
    end
  end

  task automatic send_frame(input int k, input logic [7:0] d, input int par, input int nstop,
                            input logic s2, input realtime bt);
    rx[k] = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx[k] = d[i];
      #(bt);
    end
    if (par >= 0) begin
      rx[k] = par[0];
      #(bt);
    end
    rx[k] = 1'b1;
    #(bt);
    if (nstop == 2) begin
      rx[k] = s2;
      #(bt);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    sbq[k].push_back(e);
  endtask

  task automatic wait_drain(input int k);
    for (int i = 0; i < 3000 && sbq[k].size() != 0; i++) @(posedge clk_ref);
    n_cmp++;
    if (sbq[k].size() != 0) begin
      n_bad++;
      $display("FAIL timeout_dut%0d: got %0d results pending, want 0", k, sbq[k].size());
      sbq[k].delete();
    end
  endtask

  task automatic run_table(input int k);
    int b0;
    int nb;
    int d;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].dut == k) begin
        b0 = bcnt[k];
        push(k, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        send_frame(k, vecs[i].data, vecs[i].par, vecs[i].nstop, vecs[i].s2, BitNs);
        wait_drain(k);
        // Busy runs from the start edge to the middle of the last stop bit.
        nb = 9 + ((vecs[i].par >= 0) ? 1 : 0) + vecs[i].nstop - 1;
        d  = bcnt[k] - b0;
        check($sformatf("busy_len_vec%0d", i), 32'(d >= nb * BitCyc && d < (nb + 1) * BitCyc),
              32'd1);
        if (vecs[i].s2 == 1'b1) #(BitNs);
      end
    end
  endtask

  task automatic seq_n1();
    realtime fast;
    int      v0;
    fast = BitNs / 1.02;
    push(0, 8'h55, 1'b0, 1'b0);
    push(0, 8'hAA, 1'b0, 1'b0);
    send_frame(0, 8'h55, -1, 1, 1'b1, fast);
    send_frame(0, 8'hAA, -1, 1, 1'b1, fast);
    wait_drain(0);
    #(BitNs);
    v0 = vcnt[0];
    fork
      send_frame(0, 8'hC3, -1, 1, 1'b1, BitNs);
      begin
        #(5.5 * BitNs);
        check("busy_before_reset", 32'(busy[0]), 32'd1);
        rst_x = 1'b0;
        #1;
        check("reset_mid_data", 32'(dout[0]), 32'd0);
        check("reset_mid_busy", 32'(busy[0]), 32'd0);
        check("reset_mid_valid", 32'(valid[0]), 32'd0);
      end
    join
    #(BitNs);
    check("no_valid_after_reset", 32'(vcnt[0] - v0), 32'd0);
    rst_x = 1'b1;
    #(BitNs);
    push(0, 8'h81, 1'b0, 1'b0);
    send_frame(0, 8'h81, -1, 1, 1'b1, BitNs);
    wait_drain(0);
  endtask

  task automatic seq_e1();
    int b0;
    int v0;
    int d;
    b0 = bcnt[1];
    v0 = vcnt[1];
    rx[1] = 1'b0;
    #100;
    rx[1] = 1'b1;
    #(2.0 * BitNs);
    d = bcnt[1] - b0;
    check("glitch_busy_short", 32'(d > 0 && d < BitCyc), 32'd1);
    check("glitch_no_valid", 32'(vcnt[1] - v0), 32'd0);
    check("glitch_flags_held", 32'(perr[1]), 32'd0);
  endtask

  task automatic seq_n2();
    int v0;
    v0 = vcnt[2];
    #(20.0 * BitNs);
    check("break_no_valid", 32'(vcnt[2] - v0), 32'd0);
    check("break_busy", 32'(busy[2]), 32'd0);
    check("break_ferr_held", 32'(ferr[2]), 32'd1);
    check("break_data_held", 32'(dout[2]), 32'h3C);
    rx[2] = 1'b1;
    #(2.0 * BitNs);
    push(2, 8'h96, 1'b0, 1'b0);
    send_frame(2, 8'h96, -1, 2, 1'b1, BitNs);
    wait_drain(2);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx[k]   = 1'b1;
      vcnt[k] = 0;
      bcnt[k] = 0;
      pv[k]   = 1'b0;
    end
    rst_n = 1'b0;
    rst_x = 1'b1;
    vecs[0] = '{0, 8'hA5, -1, 1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h3C,  0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h3C,  1, 1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{1, 8'h07,  1, 1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{2, 8'h7E, -1, 2, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[5] = '{2, 8'h3C, -1, 2, 1'b0, 8'h3C, 1'b0, 1'b1};

    #23;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_data_dut%0d", k), 32'(dout[k]), 32'd0);
      check($sformatf("reset_valid_dut%0d", k), 32'(valid[k]), 32'd0);
      check($sformatf("reset_busy_dut%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("reset_flags_dut%0d", k), 32'({perr[k], ferr[k], cfg[k]}), 32'd0);
    end
    #10;
    rst_n = 1'b1;
    #(BitNs);

    fork
      begin
        run_table(0);
        seq_n1();
      end
      begin
        run_table(1);
        seq_e1();
      end
      begin
        run_table(2);
        seq_n2();
      end
    join

    #(BitNs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
